// File: rtl/upsizer_packer.sv
// upsizer_packer: packs RATIO consecutive narrow W beats into one wide FIFO word,
// honouring an unaligned start lane per burst and the FIFO full flag.
module upsizer_packer #(
   parameter int NARROW_WIDTH = 32,
   parameter int WIDE_WIDTH = 128,
   localparam int RATIO = WIDE_WIDTH / NARROW_WIDTH,
   localparam int LANE_W = $clog2(RATIO),
   localparam int NSTRB = NARROW_WIDTH / 8,
   localparam int WSTRB = WIDE_WIDTH / 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_valid_i,
   input  logic [LANE_W-1:0]       cfg_lane_i,
   input  logic [NARROW_WIDTH-1:0] s_wdata_i,
   input  logic [NSTRB-1:0]        s_wstrb_i,
   input  logic                    s_wlast_i,
   input  logic                    s_wvalid_i,
   output logic                    s_wready_o,
   output logic [WIDE_WIDTH-1:0]   fifo_wdata_o,
   output logic [WSTRB-1:0]        fifo_wstrb_o,
   output logic                    fifo_wlast_o,
   output logic                    fifo_wr_valid_o,
   input  logic                    fifo_full_i
);
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t state;
   logic [LANE_W-1:0] lane;
   logic [WIDE_WIDTH-1:0] acc_data, nxt_data;
   logic [WSTRB-1:0] acc_strb, nxt_strb;
   logic out_valid, accept, complete, push;
   assign s_wready_o = (state == ACTIVE) & (!out_valid | !fifo_full_i);
   assign accept = s_wvalid_i & s_wready_o;
   assign complete = accept & (lane == LAST_LANE | s_wlast_i);
   assign push = out_valid & !fifo_full_i;
   assign fifo_wr_valid_o = out_valid;
   // accumulator with the current beat merged into its lane
   always_comb begin
      nxt_data = acc_data;
      nxt_strb = acc_strb;
      nxt_data[lane*NARROW_WIDTH +: NARROW_WIDTH] = s_wdata_i;
      nxt_strb[lane*NSTRB +: NSTRB] = s_wstrb_i;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         lane <= '0;
         acc_data <= '0;
         acc_strb <= '0;
         out_valid <= 1'b0;
         fifo_wdata_o <= '0;
         fifo_wstrb_o <= '0;
         fifo_wlast_o <= 1'b0;
      end else begin
         if (state == IDLE && cfg_valid_i) begin
            state <= ACTIVE;
            lane <= cfg_lane_i;
         end
         if (accept && s_wlast_i)
            state <= IDLE;
         if (complete) begin
            fifo_wdata_o <= nxt_data;
            fifo_wstrb_o <= nxt_strb;
            fifo_wlast_o <= s_wlast_i;
            out_valid <= 1'b1;
            acc_data <= '0;
            acc_strb <= '0;
            lane <= '0;
         end else begin
            if (accept) begin
               acc_data <= nxt_data;
               acc_strb <= nxt_strb;
               lane <= lane + LANE_W'(1);
            end
            if (push)
               out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_upsizer_packer.sv
// tb_upsizer_packer: scoreboard bench for upsizer_packer (32 -> 128 bits)
module tb_upsizer_packer;
   localparam int NW = 32, WW = 128, RATIO = 4, NS = 4, WS = 16;
   logic clk = 0, rst_n = 0;
   logic cfg_valid_i = 0, s_wlast_i = 0, s_wvalid_i = 0, fifo_full_i = 0;
   logic [1:0] cfg_lane_i = 0;
   logic [NW-1:0] s_wdata_i = 0;
   logic [NS-1:0] s_wstrb_i = 0;
   logic s_wready_o, fifo_wlast_o, fifo_wr_valid_o;
   logic [WW-1:0] fifo_wdata_o;
   logic [WS-1:0] fifo_wstrb_o;
   typedef struct {logic [WW-1:0] d; logic [WS-1:0] s; logic l;} word_t;
   word_t exp_q[$];
   logic [NW-1:0] bd[$];
   logic [NS-1:0] bs[$];
   int checks = 0, errors = 0;
   bit rand_full = 0, busy = 0;

   upsizer_packer #(.NARROW_WIDTH(NW), .WIDE_WIDTH(WW)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_valid_i(cfg_valid_i), .cfg_lane_i(cfg_lane_i),
      .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wlast_i(s_wlast_i),
      .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o), .fifo_wdata_o(fifo_wdata_o),
      .fifo_wstrb_o(fifo_wstrb_o), .fifo_wlast_o(fifo_wlast_o),
      .fifo_wr_valid_o(fifo_wr_valid_o), .fifo_full_i(fifo_full_i)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: a push happens on the next rising edge whenever valid and not full
   always @(negedge clk) begin
      word_t e;
      if (rst_n && fifo_wr_valid_o && !fifo_full_i) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_push: got %h expected no word", fifo_wdata_o);
         end else begin
            e = exp_q.pop_front();
            check("push_word", {fifo_wdata_o, fifo_wstrb_o, fifo_wlast_o}, {e.d, e.s, e.l});
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_full) fifo_full_i = ($urandom_range(0, 2) == 0);
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   task automatic send_beat(input logic [NW-1:0] d, input logic [NS-1:0] s, input bit last);
      int n = 0;
      bit acc = 0;
      s_wdata_i = d;
      s_wstrb_i = s;
      s_wlast_i = last;
      s_wvalid_i = 1;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = s_wready_o;
         @(posedge clk);
         #1;
         n++;
      end
      s_wvalid_i = 0;
      s_wlast_i = 0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: got ready 0 expected 1");
      end
   endtask

   // reference: beat i of a burst starting at lane L sits in slot (L+i) mod RATIO
   task automatic model(input int lane);
      word_t w;
      int slot;
      w.d = '0;
      w.s = '0;
      w.l = 0;
      for (int i = 0; i < bd.size(); i++) begin
         slot = (lane + i) % RATIO;
         w.d[slot*NW +: NW] = bd[i];
         w.s[slot*NS +: NS] = bs[i];
         if (slot == RATIO - 1 || i == bd.size() - 1) begin
            w.l = (i == bd.size() - 1);
            exp_q.push_back(w);
            w.d = '0;
            w.s = '0;
         end
      end
   endtask

   task automatic run_burst(input int lane, input bit bubbles, input bit noise, input bit use_model);
      cfg_lane_i = 2'(lane);
      cfg_valid_i = 1;
      @(posedge clk);
      #1;
      cfg_valid_i = 0;
      if (use_model) model(lane);
      for (int i = 0; i < bd.size(); i++) begin
         if (bubbles) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         if (noise) begin
            cfg_valid_i = 1;
            cfg_lane_i = 2'(lane + 2);
         end
         send_beat(bd[i], bs[i], i == bd.size() - 1);
      end
      cfg_valid_i = 0;
   endtask

   task automatic fill_random(input int n);
      bd.delete();
      bs.delete();
      for (int i = 0; i < n; i++) begin
         bd.push_back($urandom);
         bs.push_back(4'($urandom_range(0, 15)));
      end
   endtask

   initial begin
      int n;
      logic [159:0] held;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {s_wready_o, fifo_wr_valid_o, fifo_wlast_o, fifo_wstrb_o, fifo_wdata_o}, '0);
      rst_n = 1;
      @(posedge clk);
      #1;
      check("idle_outputs", {s_wready_o, fifo_wr_valid_o}, '0);

      bd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      bs = '{4'hF, 4'hF, 4'hF, 4'hF};
      exp_q.push_back('{128'h44444444_33333333_22222222_11111111, 16'hFFFF, 1'b1});
      run_burst(0, 0, 0, 0);
      check("aligned_latency", {fifo_wr_valid_o, s_wready_o}, {1'b1, 1'b0});

      bd = '{32'hA, 32'hB, 32'hC};
      bs = '{4'hF, 4'hF, 4'hF};
      exp_q.push_back('{128'h0000000B_0000000A_00000000_00000000, 16'hFF00, 1'b0});
      exp_q.push_back('{128'h0000000C, 16'h000F, 1'b1});
      run_burst(2, 0, 0, 0);

      fill_random(8);
      fifo_full_i = 1;
      busy = 1;
      fork
         begin
            run_burst(0, 0, 0, 1);
            busy = 0;
         end
      join_none
      n = 0;
      while (!fifo_wr_valid_o && n < 50) begin @(negedge clk); n++; end
      check("bp_valid", 160'(fifo_wr_valid_o), 160'(1));
      held = {15'b0, fifo_wdata_o, fifo_wstrb_o, fifo_wlast_o};
      repeat (5) begin
         @(negedge clk);
         check("bp_hold", {s_wready_o, 14'b0, fifo_wdata_o, fifo_wstrb_o, fifo_wlast_o}, held);
      end
      @(posedge clk);
      #1;
      fifo_full_i = 0;
      @(negedge clk);
      check("bp_release", {s_wready_o, fifo_wr_valid_o}, 2'b11);
      n = 0;
      while (busy && n < 200) begin @(posedge clk); n++; end
      check("bp_done", 160'(busy), 160'(0));
      #1;

      bd = '{32'hCAFEBABE};
      bs = '{4'h3};
      exp_q.push_back('{{64'h0, 32'hCAFEBABE, 32'h0}, 16'h0030, 1'b1});
      run_burst(1, 0, 0, 0);

      fill_random(6);
      run_burst(1, 0, 1, 1);

      bd = '{32'hDEAD0001, 32'hDEAD0002};
      bs = '{4'hF, 4'hF};
      run_burst(0, 0, 0, 0);
      #2;
      rst_n = 0;
      #1;
      check("async_reset", {s_wready_o, fifo_wr_valid_o, fifo_wlast_o, fifo_wstrb_o, fifo_wdata_o}, '0);
      @(posedge clk);
      #1;
      rst_n = 1;
      @(posedge clk);
      #1;
      bd = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
      bs = '{4'hF, 4'h1, 4'h8, 4'hF};
      exp_q.push_back('{128'h0D0E0F10_090A0B0C_05060708_01020304, 16'hF81F, 1'b1});
      run_burst(0, 0, 0, 0);

      rand_full = 1;
      repeat (40) begin
         fill_random($urandom_range(1, 10));
         run_burst($urandom_range(0, 3), 1, 1'($urandom_range(0, 1)), 1);
      end
      rand_full = 0;
      @(posedge clk);
      #1;
      fifo_full_i = 0;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(posedge clk); n++; end
      @(posedge clk);
      check("drain", 160'(exp_q.size()), 160'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
